// File: rtl/trapezoid_job_arbiter.sv
// trapezoid_job_arbiter
//   Shares one trapezoid renderer between two requester ports. Each port
//   hands over one trapezoid as four vertices (nt strobe plus three more
//   cycles of data). The arbiter holds one trapezoid per port, dispatches
//   jobs round-robin, forwards rendered pixels tagged with the owning port,
//   and reports each job's end with its pixel count. A sticky error marks a
//   renderer that never raised busy after a dispatch.
//
// Ports
//   clk, reset             clock, asynchronous active-low reset
//   nt0/xi0/yi0, busy0     requester port 0 (strobe, vertex, cannot accept)
//   nt1/xi1/yi1, busy1     requester port 1
//   r_nt/r_xi/r_yi         job dispatch to the renderer
//   r_busy                 renderer busy
//   r_po/r_xo/r_yo         renderer pixel stream
//   po/xo/yo/po_id         forwarded pixel stream with owner port
//   done/done_id/done_pix  end-of-job pulse, owner, pixel count
//   err                    sticky: renderer never accepted a job
module trapezoid_job_arbiter #(
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nt0,
  input  logic [7:0]       xi0,
  input  logic [7:0]       yi0,
  input  logic             nt1,
  input  logic [7:0]       xi1,
  input  logic [7:0]       yi1,
  output logic             busy0,
  output logic             busy1,
  output logic             r_nt,
  output logic [7:0]       r_xi,
  output logic [7:0]       r_yi,
  input  logic             r_busy,
  input  logic             r_po,
  input  logic [7:0]       r_xo,
  input  logic [7:0]       r_yo,
  output logic             po,
  output logic [7:0]       xo,
  output logic [7:0]       yo,
  output logic             po_id,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] done_pix,
  output logic             err
);

  localparam int TMR_W = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, RUN, DONE} state_t;

  state_t           state;
  logic [1:0]       cnt;
  logic             grant;
  logic             rr_last;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] pix_cnt;

  // Per-port capture state: cap_act is high while vertices 1..3 arrive.
  logic [1:0]      cap_act;
  logic [1:0]      slot_vld;
  logic [1:0][1:0] cap_idx;
  logic [7:0]      slot_x [2][4];
  logic [7:0]      slot_y [2][4];

  logic [1:0]      nt_in;
  logic [1:0][7:0] x_in;
  logic [1:0][7:0] y_in;
  logic [1:0]      port_busy;
  logic [1:0]      cap_we;
  logic [1:0][1:0] wr_idx;
  logic [1:0]      slot_clr;
  logic            pick;
  logic [1:0]      cnt_nxt;
  logic [CNT_W-1:0] pix_next;

  assign nt_in     = {nt1, nt0};
  assign x_in      = {xi1, xi0};
  assign y_in      = {yi1, yi0};
  assign port_busy = cap_act | slot_vld;
  assign busy0     = port_busy[0];
  assign busy1     = port_busy[1];
  assign cnt_nxt   = cnt + 2'd1;

  // NOTE: every signal written in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cap_we   = '0;
    wr_idx   = '0;
    slot_clr = '0;
    for (int k = 0; k < 2; k++) begin
      cap_we[k]   = cap_act[k] | (nt_in[k] & ~port_busy[k]);
      wr_idx[k]   = cap_act[k] ? cap_idx[k] : 2'd0;
      slot_clr[k] = (state == SEND) && (cnt == 2'd3) && (grant == 1'(k));
    end
    // Lone valid slot wins; on a tie the port that did not go last wins.
    pick     = (slot_vld == 2'b11) ? ~rr_last : slot_vld[1];
    pix_next = (r_po && (pix_cnt != {CNT_W{1'b1}})) ? pix_cnt + CNT_W'(1) : pix_cnt;
  end

  // Capture sequencing per port. A slot only frees once its SEND finishes,
  // so capture completion and slot clear never coincide on one port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_act  <= '0;
      slot_vld <= '0;
      cap_idx  <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!port_busy[k]) begin
          if (nt_in[k]) begin
            cap_act[k] <= 1'b1;
            cap_idx[k] <= 2'd1;
          end
        end else if (cap_act[k]) begin
          cap_idx[k] <= cap_idx[k] + 2'd1;
          if (cap_idx[k] == 2'd3) begin
            cap_act[k]  <= 1'b0;
            slot_vld[k] <= 1'b1;
          end
        end else if (slot_clr[k]) begin
          slot_vld[k] <= 1'b0;
        end
      end
    end
  end

  // NOTE: vertex storage has no reset; slot_vld alone says whether the
  // contents mean anything, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cap_we[k]) begin
        slot_x[k][wr_idx[k]] <= x_in[k];
        slot_y[k][wr_idx[k]] <= y_in[k];
      end
    end
  end

  // Dispatch FSM. r_nt/r_xi/r_yi and done* are registered one step ahead so
  // they line up with the state they belong to.
  // NOTE: non-blocking assignments throughout so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      grant    <= 1'b0;
      rr_last  <= 1'b1;
      timer    <= '0;
      pix_cnt  <= '0;
      r_nt     <= 1'b0;
      r_xi     <= '0;
      r_yi     <= '0;
      done     <= 1'b0;
      done_id  <= 1'b0;
      done_pix <= '0;
      err      <= 1'b0;
    end else begin
      r_nt     <= 1'b0;
      r_xi     <= '0;
      r_yi     <= '0;
      done     <= 1'b0;
      done_id  <= 1'b0;
      done_pix <= '0;
      case (state)
        IDLE: begin
          if (!r_busy && (slot_vld != 2'b00)) begin
            grant <= pick;
            cnt   <= 2'd0;
            state <= SEND;
            r_nt  <= 1'b1;
            r_xi  <= slot_x[pick][0];
            r_yi  <= slot_y[pick][0];
          end
        end
        SEND: begin
          if (cnt == 2'd3) begin
            timer <= '0;
            state <= WAIT_BUSY;
          end else begin
            cnt  <= cnt_nxt;
            r_xi <= slot_x[grant][cnt_nxt];
            r_yi <= slot_y[grant][cnt_nxt];
          end
        end
        WAIT_BUSY: begin
          if (r_busy) begin
            pix_cnt <= '0;
            state   <= RUN;
          end else if (timer == TMR_W'(WAIT_LIMIT - 1)) begin
            // Renderer ignored the job: drop it and let the other port go.
            err     <= 1'b1;
            rr_last <= grant;
            state   <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RUN: begin
          // A pixel in the cycle busy drops still belongs to this job.
          pix_cnt <= pix_next;
          if (!r_busy) begin
            done     <= 1'b1;
            done_id  <= grant;
            done_pix <= pix_next;
            state    <= DONE;
          end
        end
        DONE: begin
          rr_last <= grant;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel forwarding is combinational so no renderer pixel is delayed.
  assign po    = (state == RUN) & r_po;
  assign xo    = (state == RUN) ? r_xo : 8'd0;
  assign yo    = (state == RUN) ? r_yo : 8'd0;
  assign po_id = (state == RUN) ? grant : 1'b0;

endmodule

// File: tb/tb_trapezoid_job_arbiter.sv
// Bench for trapezoid_job_arbiter: stimulus pushes expected dispatches,
// pixels and job ends into queues; a renderer model and monitors pop them
// as the DUT presents r_nt, po and done.
module tb_trapezoid_job_arbiter;
  localparam int WAIT_LIMIT = 64;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             nt0 = 1'b0, nt1 = 1'b0;
  logic [7:0]       xi0 = '0, yi0 = '0, xi1 = '0, yi1 = '0;
  logic             busy0, busy1, r_nt;
  logic [7:0]       r_xi, r_yi;
  logic             r_busy = 1'b0, r_po = 1'b0;
  logic [7:0]       r_xo = '0, r_yo = '0;
  logic             po, po_id, done, done_id, err;
  logic [7:0]       xo, yo;
  logic [CNT_W-1:0] done_pix;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic            id;
    logic [3:0][7:0] xs;
    logic [3:0][7:0] ys;
    int              npix;
    bit              respond;
  } job_t;
  typedef struct { logic id; int pix; } done_t;
  typedef struct { logic id; logic [7:0] x; logic [7:0] y; } pix_t;

  job_t  plan_q[$];
  done_t done_q[$];
  pix_t  pix_q[$];

  trapezoid_job_arbiter #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .nt0(nt0), .xi0(xi0), .yi0(yi0),
    .nt1(nt1), .xi1(xi1), .yi1(yi1),
    .busy0(busy0), .busy1(busy1),
    .r_nt(r_nt), .r_xi(r_xi), .r_yi(r_yi),
    .r_busy(r_busy), .r_po(r_po), .r_xo(r_xo), .r_yo(r_yo),
    .po(po), .xo(xo), .yo(yo), .po_id(po_id),
    .done(done), .done_id(done_id), .done_pix(done_pix), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic job_t mk(input logic id,
                              input logic [7:0] x0, input logic [7:0] y0,
                              input logic [7:0] x1, input logic [7:0] y1,
                              input logic [7:0] x2, input logic [7:0] y2,
                              input logic [7:0] x3, input logic [7:0] y3,
                              input int npix, input bit respond);
    job_t j;
    j.id = id;
    j.xs[0] = x0; j.ys[0] = y0;
    j.xs[1] = x1; j.ys[1] = y1;
    j.xs[2] = x2; j.ys[2] = y2;
    j.xs[3] = x3; j.ys[3] = y3;
    j.npix = npix;
    j.respond = respond;
    return j;
  endfunction

  // Queue a job in its expected dispatch position.
  task automatic plan(input job_t j);
    done_t d;
    plan_q.push_back(j);
    if (j.respond) begin
      d.id  = j.id;
      d.pix = j.npix;
      done_q.push_back(d);
    end
  endtask

  task automatic drive_port(input logic id, input logic nt, input logic [7:0] x, input logic [7:0] y);
    if (id) begin nt1 = nt; xi1 = x; yi1 = y; end
    else    begin nt0 = nt; xi0 = x; yi0 = y; end
  endtask

  // Wait for the port to be free, then hand over four vertices. With hold
  // set, nt stays high through the capture cycles.
  task automatic send_job(input job_t j, input bit hold);
    int n = 0;
    @(posedge clk); #1;
    while ((j.id ? busy1 : busy0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("send%0d_wait_free", j.id), 32'(n < 500), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive_port(j.id, (k == 0) || hold, j.xs[k], j.ys[k]);
      @(posedge clk); #1;
    end
    drive_port(j.id, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((plan_q.size() + done_q.size() + pix_q.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(n < budget), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    plan_q.delete(); done_q.delete(); pix_q.delete();
    reset = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy0"}, 32'(busy0), 32'd0);
    check({tag, "_busy1"}, 32'(busy1), 32'd0);
    check({tag, "_r_nt"}, 32'(r_nt), 32'd0);
    check({tag, "_r_xi"}, 32'(r_xi), 32'd0);
    check({tag, "_r_yi"}, 32'(r_yi), 32'd0);
    check({tag, "_po"}, 32'(po), 32'd0);
    check({tag, "_xo"}, 32'(xo), 32'd0);
    check({tag, "_yo"}, 32'(yo), 32'd0);
    check({tag, "_po_id"}, 32'(po_id), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_done_id"}, 32'(done_id), 32'd0);
    check({tag, "_done_pix"}, 32'(done_pix), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Renderer model: checks each dispatch against the plan, then either
  // renders (busy two cycles after the last vertex, one pixel per cycle,
  // last pixel in the cycle busy drops) or stays silent and times the err.
  initial begin : renderer
    job_t j;
    bit   have;
    bit   aborted;
    int   n;
    pix_t p;
    forever begin
      @(negedge clk);
      if (reset && r_nt) begin
        have = (plan_q.size() != 0);
        check("dispatch_expected", 32'(have), 32'd1);
        if (have) j = plan_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          if (k > 0) begin
            @(negedge clk);
            check("r_nt_single_pulse", 32'(r_nt), 32'd0);
          end
          if (have) begin
            check($sformatf("dispatch_id%0d_x%0d", j.id, k), 32'(r_xi), 32'(j.xs[k]));
            check($sformatf("dispatch_id%0d_y%0d", j.id, k), 32'(r_yi), 32'(j.ys[k]));
            check($sformatf("busy%0d_during_send", j.id), 32'(j.id ? busy1 : busy0), 32'd1);
          end
        end
        @(negedge clk);
        if (have) begin
          check($sformatf("busy%0d_freed_after_send", j.id), 32'(j.id ? busy1 : busy0), 32'd0);
          if (j.respond) begin
            aborted = 1'b0;
            @(posedge clk); #1 r_busy = 1'b1;
            for (int i = 0; i < j.npix; i++) begin
              @(posedge clk); #1;
              if (!reset) begin
                aborted = 1'b1;
                break;
              end
              r_po = 1'b1;
              r_xo = j.xs[0] + 8'(i);
              r_yo = j.ys[0] + 8'(i);
              if (i == j.npix - 1) r_busy = 1'b0;
              p.id = j.id; p.x = r_xo; p.y = r_yo;
              pix_q.push_back(p);
            end
            if (!aborted) begin
              @(posedge clk); #1;
            end
            r_po = 1'b0; r_busy = 1'b0; r_xo = '0; r_yo = '0;
          end else begin
            check("err_low_before_timeout", 32'(err), 32'd0);
            n = 0;
            while (!err && n < 2 * WAIT_LIMIT) begin
              @(negedge clk);
              n++;
            end
            check("err_after_wait_limit", 32'((n >= WAIT_LIMIT) && (n <= WAIT_LIMIT + 1)), 32'd1);
          end
        end
      end
    end
  end

  always @(negedge clk) begin : pix_mon
    pix_t e;
    if (po) begin
      check("pixel_expected", 32'(pix_q.size() != 0), 32'd1);
      if (pix_q.size() != 0) begin
        e = pix_q.pop_front();
        check("pixel_po_id", 32'(po_id), 32'(e.id));
        check("pixel_xo", 32'(xo), 32'(e.x));
        check("pixel_yo", 32'(yo), 32'(e.y));
      end
    end
  end

  always @(negedge clk) begin : done_mon
    done_t e;
    if (done) begin
      check("done_expected", 32'(done_q.size() != 0), 32'd1);
      if (done_q.size() != 0) begin
        e = done_q.pop_front();
        check("done_id", 32'(done_id), 32'(e.id));
        check("done_pix", 32'(done_pix), 32'(e.pix));
      end
    end
  end

  initial begin : stimulus
    job_t a, b, c;
    int   n;

    // Reset values, during and after reset.
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("in_reset");
    reset = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("after_reset");

    // Single port 0 job, 30 pixels.
    a = mk(1'b0, 8'd10, 8'd0, 8'd20, 8'd0, 8'd5, 8'd9, 8'd25, 8'd9, 30, 1'b1);
    plan(a);
    send_job(a, 1'b0);
    drain("single", 400);

    // Both ports strobe together: port 0 first, port 1 straight after DONE.
    do_reset();
    a = mk(1'b0, 8'd30, 8'd2, 8'd40, 8'd2, 8'd28, 8'd6, 8'd44, 8'd6, 12, 1'b1);
    b = mk(1'b1, 8'd50, 8'd1, 8'd60, 8'd1, 8'd48, 8'd4, 8'd62, 8'd4, 8, 1'b1);
    plan(a);
    plan(b);
    fork
      send_job(a, 1'b0);
      send_job(b, 1'b0);
    join
    n = 0;
    while (done_q.size() != 1 && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    check("tie_first_done_seen", 32'(n < 300), 32'd1);
    check("tie_busy1_held_after_done0", 32'(busy1), 32'd1);
    @(posedge clk); #2;
    check("tie_port1_dispatch_after_idle", 32'(r_nt), 32'd1);
    drain("tie", 400);

    // Port 0 streams while port 1 waits: order 0,1,0.
    do_reset();
    a = mk(1'b0, 8'd1, 8'd10, 8'd9, 8'd10, 8'd0, 8'd14, 8'd11, 8'd14, 10, 1'b1);
    b = mk(1'b1, 8'd70, 8'd20, 8'd80, 8'd20, 8'd66, 8'd30, 8'd84, 8'd30, 5, 1'b1);
    c = mk(1'b0, 8'd100, 8'd40, 8'd110, 8'd40, 8'd98, 8'd44, 8'd112, 8'd44, 4, 1'b1);
    plan(a);
    plan(b);
    plan(c);
    fork
      begin
        send_job(a, 1'b0);
        send_job(c, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        send_job(b, 1'b0);
      end
    join
    drain("stream", 600);

    // nt0 held through capture and pulsed with junk while busy0 is high.
    do_reset();
    a = mk(1'b1, 8'd200, 8'd50, 8'd210, 8'd50, 8'd195, 8'd60, 8'd215, 8'd60, 20, 1'b1);
    b = mk(1'b0, 8'd3, 8'd70, 8'd7, 8'd70, 8'd2, 8'd75, 8'd8, 8'd75, 3, 1'b1);
    plan(a);
    plan(b);
    send_job(a, 1'b0);
    send_job(b, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_port(1'b0, 1'b1, 8'hEE, 8'hEE);
      check("busy0_while_junk_nt", 32'(busy0), 32'd1);
      @(posedge clk); #1;
    end
    drive_port(1'b0, 1'b0, 8'd0, 8'd0);
    drain("ignore_nt", 400);

    // Renderer ignores port 0's job; port 1's job still runs afterwards.
    do_reset();
    a = mk(1'b0, 8'd11, 8'd1, 8'd22, 8'd1, 8'd10, 8'd5, 8'd23, 8'd5, 0, 1'b0);
    b = mk(1'b1, 8'd33, 8'd7, 8'd44, 8'd7, 8'd30, 8'd9, 8'd47, 8'd9, 6, 1'b1);
    plan(a);
    plan(b);
    fork
      send_job(a, 1'b0);
      send_job(b, 1'b0);
    join
    drain("timeout", 400);
    check("err_sticky", 32'(err), 32'd1);

    // Reset in the middle of a run with both slots occupied and err set.
    a = mk(1'b0, 8'd120, 8'd100, 8'd130, 8'd100, 8'd118, 8'd110, 8'd132, 8'd110, 40, 1'b1);
    b = mk(1'b0, 8'd5, 8'd5, 8'd6, 8'd5, 8'd4, 8'd6, 8'd7, 8'd6, 3, 1'b1);
    c = mk(1'b1, 8'd9, 8'd9, 8'd10, 8'd9, 8'd8, 8'd10, 8'd11, 8'd10, 3, 1'b1);
    plan(a);
    send_job(a, 1'b0);
    fork
      send_job(b, 1'b0);
      send_job(c, 1'b0);
    join
    n = 0;
    while (!po && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("run_started_before_reset", 32'(n < 200), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_po", 32'(po), 32'd1);
    check("pre_reset_busy0", 32'(busy0), 32'd1);
    check("pre_reset_busy1", 32'(busy1), 32'd1);
    check("pre_reset_err", 32'(err), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mid_reset_po", 32'(po), 32'd0);
    check("mid_reset_done", 32'(done), 32'd0);
    check("mid_reset_busy0", 32'(busy0), 32'd0);
    check("mid_reset_busy1", 32'(busy1), 32'd0);
    check("mid_reset_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    plan_q.delete(); done_q.delete(); pix_q.delete();
    reset = 1'b1;
    a = mk(1'b1, 8'd60, 8'd60, 8'd70, 8'd60, 8'd58, 8'd66, 8'd72, 8'd66, 7, 1'b1);
    plan(a);
    send_job(a, 1'b0);
    drain("after_reset", 400);
    check("err_clear_after_reset", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
